// File: rtl/tile_seq_pkg.sv
// Shared definitions for tile_sequencer: FSM state encoding, bit positions of
// the 34-bit core instruction word, the idle instruction and the field packer.
// Latency: none (types/functions only). Backpressure: not applicable.
package tile_seq_pkg;

  localparam int INST_W = 34;
  localparam int A_W    = 11;  // width of the A_pmem / A_xmem instruction fields

  // Instruction word bit positions
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both SRAMs disabled (CEN/WEN high), everything else quiet
  localparam logic [INST_W-1:0] INST_IDLE = 34'h1800C0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_RD,
    S_W_LD,
    S_W_SETTLE,
    S_X_RD,
    S_EXEC,
    S_DRAIN_RD,
    S_DRAIN_WR,
    S_DONE
  } state_t;

  typedef struct packed {
    logic           acc;
    logic           cen_p;
    logic           wen_p;
    logic [A_W-1:0] a_p;
    logic           cen_x;
    logic           wen_x;
    logic [A_W-1:0] a_x;
    logic           ofifo_rd;
    logic           ififo_wr;
    logic           ififo_rd;
    logic           l0_rd;
    logic           l0_wr;
    logic           execute;
    logic           load;
  } inst_f_t;

  function automatic inst_f_t idle_fields();
    inst_f_t f;
    f       = '0;
    f.cen_p = 1'b1;
    f.wen_p = 1'b1;
    f.cen_x = 1'b1;
    f.wen_x = 1'b1;
    return f;
  endfunction

  // Places each field at its documented bit position
  function automatic logic [INST_W-1:0] pack_inst(input inst_f_t f);
    logic [INST_W-1:0] w;
    w                   = '0;
    w[B_ACC]            = f.acc;
    w[B_CEN_P]          = f.cen_p;
    w[B_WEN_P]          = f.wen_p;
    w[B_AP_LSB +: A_W]  = f.a_p;
    w[B_CEN_X]          = f.cen_x;
    w[B_WEN_X]          = f.wen_x;
    w[B_AX_LSB +: A_W]  = f.a_x;
    w[B_OFIFO_RD]       = f.ofifo_rd;
    w[B_IFIFO_WR]       = f.ififo_wr;
    w[B_IFIFO_RD]       = f.ififo_rd;
    w[B_L0_RD]          = f.l0_rd;
    w[B_L0_WR]          = f.l0_wr;
    w[B_EXEC]           = f.execute;
    w[B_LOAD]           = f.load;
    return w;
  endfunction

endpackage

// File: rtl/tile_sequencer.sv
// Sequences one systolic-array tile: weight load, activation stream, psum drain.
// Latency: inst/busy/done are registered; first instruction one cycle after start.
// Backpressure: drain entries wait on ofifo_valid (INST_IDLE while low); start ignored while busy.
//
// Ports: clk, reset (async active-low), start, acc_en, w_base/x_base/p_base
// (sampled on accepted start), ofifo_valid; inst (34-bit instruction word),
// busy, done (one-cycle pulse). Optional macro TILE_SEQ_ABORT_EN adds input
// abort, which returns any busy state to IDLE with no done pulse.
module tile_sequencer
  import tile_seq_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int LEN_NIJ = 36,
  parameter int AW      = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          acc_en,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] x_base,
  input  logic [AW-1:0] p_base,
  input  logic          ofifo_valid,
`ifdef TILE_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic [33:0]   inst,
  output logic          busy,
  output logic          done
);

  localparam logic [6:0] ROW_C       = 7'(row);
  localparam logic [6:0] LEN_C       = 7'(LEN_NIJ);
  localparam logic [6:0] SETTLE_LAST = 7'(row + col - 1);

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;      // shared phase counter / drain index k
  logic                go_q, go_d;        // current drain cycle actually issues
  logic                acc_q, acc_d;
  logic [AW-1:0]       w_base_q, w_base_d;
  logic [AW-1:0]       x_base_q, x_base_d;
  logic [AW-1:0]       p_base_q, p_base_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                abort_req;
  inst_f_t             f;

`ifdef TILE_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    go_d     = 1'b0;
    acc_d    = acc_q;
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    p_base_d = p_base_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort_req) begin
          state_d  = S_W_RD;
          cnt_d    = '0;
          acc_d    = acc_en;
          w_base_d = w_base;
          x_base_d = x_base;
          p_base_d = p_base;
        end
      end
      S_W_RD: begin
        if (cnt_q == ROW_C) begin
          state_d = S_W_LD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_W_LD: begin
        if (cnt_q == ROW_C - 7'd1) begin
          state_d = S_W_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_W_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_X_RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_X_RD: begin
        if (cnt_q == LEN_C) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_EXEC: begin
        if (cnt_q == LEN_C - 7'd1) begin
          state_d = acc_q ? S_DRAIN_RD : S_DRAIN_WR;
          cnt_d   = '0;
          go_d    = ofifo_valid;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DRAIN_RD: begin
        if (go_q) begin
          // write half of the pair follows unconditionally
          state_d = S_DRAIN_WR;
          go_d    = 1'b1;
        end else begin
          go_d = ofifo_valid;
        end
      end
      S_DRAIN_WR: begin
        if (go_q) begin
          if (cnt_q == LEN_C - 7'd1) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = acc_q ? S_DRAIN_RD : S_DRAIN_WR;
            cnt_d   = cnt_q + 7'd1;
            go_d    = ofifo_valid;
          end
        end else begin
          go_d = ofifo_valid;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort_req && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      go_d    = 1'b0;
    end
  end

  // Instruction for the cycle being entered, so inst lines up with state_q
  always_comb begin
    f = idle_fields();
    unique case (state_d)
      S_W_RD: begin
        if (cnt_d < ROW_C) begin
          f.cen_x = 1'b0;
          f.a_x   = A_W'(w_base_d + AW'(cnt_d));
        end
        // L0 write trails the SRAM read by one cycle
        f.l0_wr = (cnt_d != 7'd0);
      end
      S_W_LD: begin
        f.l0_rd = 1'b1;
        f.load  = 1'b1;
      end
      S_X_RD: begin
        if (cnt_d < LEN_C) begin
          f.cen_x = 1'b0;
          f.a_x   = A_W'(x_base_d + AW'(cnt_d));
        end
        f.l0_wr = (cnt_d != 7'd0);
      end
      S_EXEC: begin
        f.l0_rd   = 1'b1;
        f.execute = 1'b1;
      end
      S_DRAIN_RD: begin
        if (go_d) begin
          f.cen_p = 1'b0;
          f.a_p   = A_W'(p_base_d + AW'(cnt_d));
        end
      end
      S_DRAIN_WR: begin
        if (go_d) begin
          f.ofifo_rd = 1'b1;
          f.cen_p    = 1'b0;
          f.wen_p    = 1'b0;
          f.a_p      = A_W'(p_base_d + AW'(cnt_d));
          f.acc      = acc_d;
        end
      end
      default: begin
      end
    endcase
    inst_d = pack_inst(f);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      go_q     <= 1'b0;
      acc_q    <= 1'b0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      inst_q   <= INST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      go_q     <= go_d;
      acc_q    <= acc_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      p_base_q <= p_base_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: expected non-idle instruction words
// and done markers are queued at start time; a negedge monitor pops/compares.
module tb_tile_sequencer;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int LEN  = 36;
  localparam logic [33:0] IDLE_W = 34'h1800C0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        acc_en;
  logic [10:0] w_base, x_base, p_base;
  logic        ofifo_valid;
`ifdef TILE_SEQ_ABORT_EN
  logic        abort;
`endif
  logic [33:0] inst;
  logic        busy, done;

  always #5 clk = ~clk;

  tile_sequencer #(.row(ROW), .col(COL), .LEN_NIJ(LEN), .AW(11)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_en(acc_en),
    .w_base(w_base), .x_base(x_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid),
`ifdef TILE_SEQ_ABORT_EN
    .abort(abort),
`endif
    .inst(inst), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  logic [34:0] exp_q[$];   // bit 34 marks the done pulse
  int  busy_cnt, done_cnt, ofrd_cnt, settle_gap, cyc, last_load;
  bit  seen_load;
  int  ov_mode = 0;        // 0 held high, 1 toggling, 2 random
  logic ov_edge;

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Spec bit map built directly from field meanings
  function automatic logic [33:0] mk(input bit acc, input bit cenp, input bit wenp, input int ap,
                                     input bit cenx, input int ax, input bit ofrd, input bit l0rd,
                                     input bit l0wr, input bit ex, input bit ld);
    logic [33:0] w;
    logic [10:0] a1, a2;
    a1 = ap[10:0];
    a2 = ax[10:0];
    w = '0;
    w[33] = acc; w[32] = cenp; w[31] = wenp; w[30:20] = a1;
    w[19] = cenx; w[18] = 1'b1; w[17:7] = a2;
    w[6] = ofrd; w[3] = l0rd; w[2] = l0wr; w[1] = ex; w[0] = ld;
    return w;
  endfunction

  task automatic push_tile(input int wb, input int xb, input int pb, input bit acc);
    for (int i = 0; i <= ROW; i++)
      exp_q.push_back({1'b0, mk(0, 1, 1, 0, (i < ROW) ? 1'b0 : 1'b1,
                                (i < ROW) ? (wb + i) % 2048 : 0, 0, 0, i >= 1, 0, 0)});
    for (int i = 0; i < ROW; i++)
      exp_q.push_back({1'b0, mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1)});
    for (int i = 0; i <= LEN; i++)
      exp_q.push_back({1'b0, mk(0, 1, 1, 0, (i < LEN) ? 1'b0 : 1'b1,
                                (i < LEN) ? (xb + i) % 2048 : 0, 0, 0, i >= 1, 0, 0)});
    for (int i = 0; i < LEN; i++)
      exp_q.push_back({1'b0, mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0)});
    for (int k = 0; k < LEN; k++) begin
      if (acc) exp_q.push_back({1'b0, mk(0, 0, 1, (pb + k) % 2048, 1, 0, 0, 0, 0, 0, 0)});
      exp_q.push_back({1'b0, mk(acc, 0, 0, (pb + k) % 2048, 1, 0, 1, 0, 0, 0, 0)});
    end
    exp_q.push_back({1'b1, IDLE_W});
  endtask

  always @(posedge clk) ov_edge <= ofifo_valid;

  always @(posedge clk) begin
    #1;
    case (ov_mode)
      0: ofifo_valid = 1'b1;
      1: ofifo_valid = ~ofifo_valid;
      default: ofifo_valid = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor
  always @(negedge clk) begin
    logic [34:0] item;
    if (reset) begin
      cyc++;
      if (busy) busy_cnt++;
      if (done || inst != IDLE_W) begin
        if (done) done_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got inst %h done %0b want nothing", inst, done);
        end else begin
          item = exp_q.pop_front();
          chk("sb_word", {done, inst}, item);
        end
        if (!done) begin
          if (inst[6]) ofrd_cnt++;
          // a drain entry may only begin after ofifo_valid was seen high
          if (!inst[32] && (inst[31] || !inst[33])) chk("drain_gate", ov_edge, 1);
          if (inst[0]) begin
            seen_load = 1; last_load = cyc;
          end else if (seen_load) begin
            settle_gap = cyc - last_load - 1; seen_load = 0;
          end
        end
      end
    end
  end

  task automatic start_tile(input int wb, input int xb, input int pb, input bit acc);
    busy_cnt = 0; done_cnt = 0; ofrd_cnt = 0; settle_gap = -1; seen_load = 0;
    push_tile(wb, xb, pb, acc);
    @(posedge clk); #1;
    start = 1; acc_en = acc; w_base = 11'(wb); x_base = 11'(xb); p_base = 11'(pb);
    @(posedge clk); #1;
    start = 0; acc_en = $urandom_range(0, 1);
    w_base = 11'($urandom); x_base = 11'($urandom); p_base = 11'($urandom);
  endtask

  task automatic wait_done(input string nm, input int exp_busy);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk); n++;
    end
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done want done within 3000 cycles", nm);
    end
    repeat (3) @(negedge clk);
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_inst_idle"}, inst, IDLE_W);
    chk({nm, "_busy_low"}, busy, 0);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    chk({nm, "_settle_gap"}, settle_gap, ROW + COL);
    chk({nm, "_ofifo_rd"}, ofrd_cnt, LEN);
    if (exp_busy >= 0) chk({nm, "_busy_cycles"}, busy_cnt, exp_busy);
    exp_q.delete();
  endtask

  initial begin
    reset = 1; start = 0; acc_en = 0; w_base = 0; x_base = 0; p_base = 0;
    ofifo_valid = 1;
`ifdef TILE_SEQ_ABORT_EN
    abort = 0;
`endif
    #2 reset = 0;
    #1;
    chk("rst_inst", inst, IDLE_W);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    repeat (3) @(negedge clk);
    chk("idle_inst", inst, IDLE_W);

    // Baseline tile, no accumulate: 9+8+16+37+36+36 plus one DONE cycle
    ov_mode = 0;
    start_tile(0, 16, 0, 0);
    wait_done("base", 143);

    // Accumulate: 72 drain cycles
    start_tile(5, 100, 300, 1);
    wait_done("acc", 179);

    // ofifo_valid toggling during drain
    ov_mode = 1;
    start_tile(7, 40, 77, 0);
    wait_done("tog0", -1);
    start_tile(9, 60, 500, 1);
    wait_done("tog1", -1);
    ov_mode = 0;

    // Address wrap on weights, activations and psums
    start_tile(2046, 2030, 2040, 1);
    wait_done("wrap", 179);

    // start while busy is ignored
    start_tile(0, 16, 0, 0);
    repeat (80) @(posedge clk);
    #1;
    chk("in_exec", inst[1], 1);
    start = 1; w_base = 11'd300; acc_en = 1;
    @(posedge clk); #1 start = 0;
    wait_done("busy_start", 143);

    // Reset in the middle of X_RD
    start_tile(1, 200, 3, 1);
    repeat (40) @(posedge clk);
    #2;
    chk("in_xrd", inst[19], 0);
    reset = 0;
    exp_q.delete(); seen_load = 0;
    #1;
    chk("midrst_inst", inst, IDLE_W);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    start_tile(10, 20, 30, 0);
    wait_done("recover", 143);

`ifdef TILE_SEQ_ABORT_EN
    start_tile(4, 50, 90, 1);
    repeat (110) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1;
    abort = 0;
    exp_q.delete(); seen_load = 0;
    repeat (5) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_inst", inst, IDLE_W);
    chk("abort_no_done", done_cnt, 0);
`endif

    // Random tiles with random ofifo_valid
    ov_mode = 2;
    for (int t = 0; t < 6; t++) begin
      start_tile($urandom_range(0, 2047), $urandom_range(0, 2047),
                 $urandom_range(0, 2047), 1'($urandom_range(0, 1)));
      wait_done("rand", -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
